// File: rtl/btb_assoc_pkg.sv
// Shared types and constants for the set-associative branch target buffer.
package btb_assoc_pkg;

    typedef enum logic {
        ST_FLUSH = 1'b0,
        ST_IDLE  = 1'b1
    } btb_state_e;

    localparam logic [1:0] BR_PC_RELATIVE = 2'd0;
    localparam logic [1:0] BR_INDIRECT    = 2'd1;
    localparam logic [1:0] BR_RETURN      = 2'd2;
    localparam logic [1:0] BR_CALL        = 2'd3;

    // Way-select width; a direct-mapped BTB still carries a 1-bit way field.
    function automatic int way_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/btb_assoc_sdpram.sv
// Simple dual-port RAM, one write port and one registered read port.
// A read and a write to the same address in one cycle return the old data.
module btb_assoc_sdpram #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata <= '0;
        else        rdata <= mem[raddr];
    end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative BTB: 1-cycle lookup, per-set round-robin allocation,
// hinted overwrite and a one-set-per-cycle flush sweep after reset or on request.
//
// state    | meaning
// ST_FLUSH | sweeping sets 0..2^ADDR_WIDTH-1, writing invalid entries; lookups miss
// ST_IDLE  | serving lookups and accepting updates
module btb_assoc
    import btb_assoc_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int WAYS       = 2,
    parameter int TAG_WIDTH  = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [29:0]                rpc,
    input  logic                       update,
    input  logic                       upd_hit,
    input  logic [way_bits(WAYS)-1:0]  upd_way,
    input  logic [29:0]                wpc,
    input  logic [29:0]                wbta,
    input  logic [1:0]                 wbr_type,
    input  logic                       flush,
    output logic                       ready,
    output logic                       miss,
    output logic                       fsc,
    output logic [way_bits(WAYS)-1:0]  hit_way,
    output logic [29:0]                bta,
    output logic [1:0]                 br_type
);

    localparam int WW   = way_bits(WAYS);
    localparam int SETS = 1 << ADDR_WIDTH;

    typedef struct packed {
        logic                 valid;
        logic                 fsc;
        logic [TAG_WIDTH-1:0] tag;
        logic [29:0]          bta;
        logic [1:0]           br_type;
    } entry_t;

    localparam int EW = $bits(entry_t);

    // pc arguments are word addresses (byte bits [31:2]).
    function automatic logic [ADDR_WIDTH-1:0] pc_index(input logic [29:0] pc);
        return pc[ADDR_WIDTH:1];
    endfunction

    function automatic logic [TAG_WIDTH-1:0] pc_tag(input logic [29:0] pc);
        return pc[29 -: TAG_WIDTH] ^ pc[ADDR_WIDTH+1 +: TAG_WIDTH];
    endfunction

    btb_state_e              state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [29:0]             pre_pc;
    logic [WW-1:0]           rr [SETS];
    logic [WW-1:0]           rr_next;
    logic                    flushing, do_update;
    logic [ADDR_WIDTH-1:0]   wr_idx, wr_addr, rd_addr;
    logic [WW-1:0]           tgt_way;
    entry_t                  wr_entry;
    logic [EW-1:0]           wr_data;
    logic [WAYS-1:0]         way_we;
    logic [EW-1:0]           rd_raw [WAYS];
    entry_t                  rd_entry [WAYS];
    logic                    hit_any;
    logic [WW-1:0]           hit_sel;
    logic                    unused_bits;

    assign unused_bits = pre_pc[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FLUSH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_FLUSH: begin
                if (flush) begin
                    cnt_d = '0;
                end else if (cnt_q == '1) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (flush) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_FLUSH;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        flushing  = (state_q == ST_FLUSH);
        ready     = ~flushing;
        do_update = ~flushing & update & ~flush;
    end

    assign wr_idx  = pc_index(wpc);
    assign rd_addr = pc_index(rpc);
    assign rr_next = (WAYS == 1) ? '0 : rr[wr_idx] + WW'(1);

    always_comb begin
        tgt_way  = upd_hit ? upd_way : rr[wr_idx];
        wr_addr  = flushing ? cnt_q : wr_idx;
        wr_entry = '0;
        if (!flushing) begin
            wr_entry.valid   = 1'b1;
            wr_entry.fsc     = wpc[0];
            wr_entry.tag     = pc_tag(wpc);
            wr_entry.bta     = wbta;
            wr_entry.br_type = wbr_type;
        end
        for (int w = 0; w < WAYS; w++) begin
            way_we[w] = flushing | (do_update & (tgt_way == WW'(w)));
        end
    end

    assign wr_data = wr_entry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) rr[s] <= '0;
        end else if (do_update && !upd_hit) begin
            rr[wr_idx] <= rr_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pre_pc <= '0;
        else        pre_pc <= rpc;
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        btb_assoc_sdpram #(
            .AW (ADDR_WIDTH),
            .DW (EW)
        ) u_ram (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (way_we[w]),
            .waddr (wr_addr),
            .wdata (wr_data),
            .raddr (rd_addr),
            .rdata (rd_raw[w])
        );
        assign rd_entry[w] = entry_t'(rd_raw[w]);
    end

    // Descending scan so the lowest matching way is the one that sticks.
    always_comb begin
        hit_any = 1'b0;
        hit_sel = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (rd_entry[w].valid && (rd_entry[w].tag == pc_tag(pre_pc))) begin
                hit_any = 1'b1;
                hit_sel = WW'(w);
            end
        end
    end

    always_comb begin
        miss    = 1'b1;
        fsc     = 1'b0;
        hit_way = '0;
        bta     = {pre_pc[29:1] + 29'd1, 1'b0};
        br_type = BR_PC_RELATIVE;
        if (!flushing && hit_any) begin
            miss    = 1'b0;
            fsc     = rd_entry[hit_sel].fsc;
            hit_way = hit_sel;
            bta     = rd_entry[hit_sel].bta;
            br_type = rd_entry[hit_sel].br_type;
        end
    end

endmodule

// File: tb/tb_btb_assoc.sv
// Bench for btb_assoc: directed scenarios plus randomized traffic checked
// every cycle against an array-based model of the BTB contents.
module tb_btb_assoc;
    import btb_assoc_pkg::*;

    localparam int AW   = 8;
    localparam int WAYS = 2;
    localparam int TW   = 15;
    localparam int WW   = 1;
    localparam int SETS = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [29:0]   rpc, wpc, wbta, bta;
    logic          update, upd_hit, flush, ready, miss, fsc;
    logic [WW-1:0] upd_way, hit_way;
    logic [1:0]    wbr_type, br_type;

    int tests  = 0;
    int failed = 0;
    int low_cnt;
    int n;

    bit          m_valid [WAYS][SETS];
    bit          m_fsc   [WAYS][SETS];
    logic [TW-1:0] m_tag [WAYS][SETS];
    logic [29:0] m_bta   [WAYS][SETS];
    logic [1:0]  m_type  [WAYS][SETS];
    int          m_rr    [SETS];
    bit          m_flushing;
    int          m_cnt;

    logic [29:0] p0, p1, p2, p3, pd;

    always #5 clk = ~clk;

    btb_assoc #(.ADDR_WIDTH(AW), .WAYS(WAYS), .TAG_WIDTH(TW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rpc      (rpc),
        .update   (update),
        .upd_hit  (upd_hit),
        .upd_way  (upd_way),
        .wpc      (wpc),
        .wbta     (wbta),
        .wbr_type (wbr_type),
        .flush    (flush),
        .ready    (ready),
        .miss     (miss),
        .fsc      (fsc),
        .hit_way  (hit_way),
        .bta      (bta),
        .br_type  (br_type)
    );

    function automatic logic [29:0] wa(input logic [31:0] b);
        return b[31:2];
    endfunction

    function automatic int set_of(input logic [29:0] pc);
        logic [31:0] b;
        b = {pc, 2'b00};
        return int'((b >> 3) % SETS);
    endfunction

    function automatic logic [TW-1:0] tag_of(input logic [29:0] pc);
        logic [31:0] b, t;
        b = {pc, 2'b00};
        t = (b >> 17) ^ (b >> 11);
        return t[TW-1:0];
    endfunction

    function automatic logic [29:0] pool_pc();
        logic [31:0] b;
        b = 32'h0001_0000 + 32'($urandom_range(0, 3)) * 32'h800
            + 32'($urandom_range(0, 3)) * 32'd8 + 32'($urandom_range(0, 1)) * 32'd4;
        return b[31:2];
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_flushing = 1'b1;
        m_cnt      = 0;
        for (int s = 0; s < SETS; s++) m_rr[s] = 0;
    endtask

    // One clock: predict from the contents before this edge's write, then
    // apply the edge's effect on the model, then compare after the edge.
    task automatic tick();
        logic [31:0] b, fb;
        logic [35:0] e;
        int s, hw, ws, way;
        bit hit, h_fsc;
        logic [29:0] h_bta;
        logic [1:0]  h_type;
        b = {rpc, 2'b00};
        s = set_of(rpc);
        hit = 1'b0; hw = 0; h_fsc = 1'b0; h_bta = '0; h_type = '0;
        for (int k = 0; k < WAYS; k++) begin
            if (!hit && m_valid[k][s] && m_tag[k][s] == tag_of(rpc)) begin
                hit = 1'b1; hw = k;
                h_fsc = m_fsc[k][s]; h_bta = m_bta[k][s]; h_type = m_type[k][s];
            end
        end
        if (m_flushing) begin
            for (int k = 0; k < WAYS; k++) m_valid[k][m_cnt] = 1'b0;
            if (flush)                 m_cnt = 0;
            else if (m_cnt == SETS-1)  m_flushing = 1'b0;
            else                       m_cnt++;
        end else if (flush) begin
            m_flushing = 1'b1;
            m_cnt      = 0;
        end else if (update) begin
            ws = set_of(wpc);
            if (upd_hit) way = int'(upd_way);
            else begin
                way = m_rr[ws];
                m_rr[ws] = (m_rr[ws] + 1) % WAYS;
            end
            m_valid[way][ws] = 1'b1;
            m_fsc[way][ws]   = wpc[0];
            m_tag[way][ws]   = tag_of(wpc);
            m_bta[way][ws]   = wbta;
            m_type[way][ws]  = wbr_type;
        end
        if (hit && !m_flushing) begin
            e = {1'b1, 1'b0, h_fsc, WW'(hw), h_bta, h_type};
        end else begin
            fb = ((b >> 3) + 32'd1) << 3;
            e = {~m_flushing, 1'b1, 1'b0, {WW{1'b0}}, fb[31:2], BR_PC_RELATIVE};
        end
        @(posedge clk);
        #1;
        check("lookup", {28'b0, ready, miss, fsc, hit_way, bta, br_type}, {28'b0, e});
        if (!ready) low_cnt++;
    endtask

    task automatic alloc(input logic [29:0] pc, input logic [29:0] tgt, input logic [1:0] ty);
        update = 1'b1; upd_hit = 1'b0; wpc = pc; wbta = tgt; wbr_type = ty;
        tick();
        update = 1'b0;
    endtask

    task automatic look(input logic [29:0] pc);
        rpc = pc;
        tick();
    endtask

    task automatic wait_ready();
        n = 0;
        low_cnt = 0;
        while (!ready && n < 800) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < WAYS; k++)
            for (int s = 0; s < SETS; s++) m_valid[k][s] = 1'b0;
        model_reset();
        rst_n = 1'b0; update = 1'b0; upd_hit = 1'b0; upd_way = '0; flush = 1'b0;
        wpc = '0; wbta = '0; wbr_type = '0; rpc = wa(32'h1000);
        #12;
        check("reset_vals", {28'b0, ready, miss, fsc, hit_way, bta, br_type},
              {28'b0, 1'b0, 1'b1, 1'b0, 1'b0, 30'h2, BR_PC_RELATIVE});
        @(negedge clk);
        rst_n = 1'b1;

        wait_ready();
        check("reset_sweep_len", 64'(n), 64'd256);
        check("post_flush_miss", 64'(miss), 64'd1);
        check("post_flush_bta", 64'(bta), 64'(wa(32'h1008)));

        // Allocate then look up the same branch.
        rpc = wa(32'h1000);
        alloc(wa(32'h1004), wa(32'h2000), BR_CALL);
        look(wa(32'h1004));
        check("alloc_miss", 64'(miss), 64'd0);
        check("alloc_fsc", 64'(fsc), 64'd1);
        check("alloc_way", 64'(hit_way), 64'd0);
        check("alloc_bta", 64'(bta), 64'(wa(32'h2000)));

        // Three PCs sharing set 2: the third evicts the first.
        p0 = wa(32'h4010); p1 = wa(32'h4810); p2 = wa(32'h5010); p3 = wa(32'h5810);
        alloc(p0, wa(32'hA000), BR_PC_RELATIVE);
        alloc(p1, wa(32'hB000), BR_INDIRECT);
        alloc(p2, wa(32'hC000), BR_RETURN);
        look(p0);
        check("conflict_evicted", 64'(miss), 64'd1);
        look(p1);
        check("conflict_p1_way", 64'({miss, hit_way}), 64'({1'b0, 1'b1}));
        look(p2);
        check("conflict_p2_way", 64'({miss, hit_way}), 64'({1'b0, 1'b0}));

        // Hinted overwrite of way 1 leaves the round-robin pointer alone.
        update = 1'b1; upd_hit = 1'b1; upd_way = 1'b1; wpc = p1; wbta = wa(32'h3000);
        wbr_type = BR_CALL;
        tick();
        update = 1'b0; upd_hit = 1'b0; upd_way = '0;
        look(p1);
        check("hint_bta", 64'(bta), 64'(wa(32'h3000)));
        check("hint_way", 64'(hit_way), 64'd1);
        alloc(p3, wa(32'hD000), BR_PC_RELATIVE);
        look(p3);
        check("hint_rr_way", 64'({miss, hit_way}), 64'({1'b0, 1'b1}));
        look(p2);
        check("hint_p2_kept", 64'({miss, hit_way}), 64'({1'b0, 1'b0}));
        look(p1);
        check("hint_p1_evicted", 64'(miss), 64'd1);

        // Randomized traffic over a small pool so sets conflict and hit.
        for (int i = 0; i < 300; i++) begin
            rpc      = pool_pc();
            wpc      = pool_pc();
            update   = 1'($urandom_range(0, 1));
            upd_hit  = ($urandom_range(0, 3) == 0);
            upd_way  = WW'($urandom_range(0, WAYS - 1));
            wbta     = 30'($urandom);
            wbr_type = 2'($urandom);
            tick();
        end
        update = 1'b0; upd_hit = 1'b0;

        // Flush and update in the same cycle: flush wins.
        pd = wa(32'h6020);
        rpc = p2;
        alloc(p2, wa(32'hE000), BR_INDIRECT);
        low_cnt = 0;
        update = 1'b1; flush = 1'b1; wpc = pd; wbta = wa(32'h7000);
        tick();
        update = 1'b0; flush = 1'b0;
        n = 0;
        while (!ready && n < 800) begin
            tick();
            n++;
        end
        check("flush_low_cycles", 64'(low_cnt), 64'd256);
        look(p2);
        check("flush_p2_miss", 64'(miss), 64'd1);
        look(pd);
        check("flush_dropped_upd", 64'(miss), 64'd1);
        look(wa(32'h1004));
        check("flush_old_miss", 64'(miss), 64'd1);

        // flush during a sweep restarts it from set 0.
        alloc(p0, wa(32'h9000), BR_CALL);
        low_cnt = 0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n = 0;
        while (!ready && n < 800) begin
            tick();
            n++;
        end
        check("flush_restart_low", 64'(low_cnt), 64'd357);

        // Reset in the middle of a sweep.
        alloc(p1, wa(32'h8000), BR_RETURN);
        rpc = p1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midflush_reset_vals", {28'b0, ready, miss, fsc, hit_way, bta, br_type},
              {28'b0, 1'b0, 1'b1, 1'b0, 1'b0, 30'h2, BR_PC_RELATIVE});
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready();
        check("midflush_sweep_len", 64'(n), 64'd256);
        look(p1);
        check("midflush_p1_miss", 64'(miss), 64'd1);
        alloc(p1, wa(32'h8800), BR_CALL);
        look(p1);
        check("post_reset_alloc", 64'({miss, hit_way, bta}), 64'({1'b0, 1'b0, wa(32'h8800)}));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/btb_assoc.md
# btb_assoc

Parametrised set-associative branch target buffer; successor to the direct-mapped BTB in the BPU. It adds configurable ways and tag width, per-set round-robin replacement, hinted update/allocate, and a sequential flush engine that sweeps the RAM after reset or on request. It sits in the fetch stage beside the PHT: a PC is presented in cycle N, and target, type and hit way come back in cycle N+1.

## Interface
- ADDR_WIDTH, 8: log2 of number of sets; index = pc[ADDR_WIDTH+2:3]
- WAYS, 2: associativity, power of two, 1..4
- TAG_WIDTH, 15: tag = pc[31 -: TAG_WIDTH] ^ pc[ADDR_WIDTH+3 +: TAG_WIDTH]; legal only if ADDR_WIDTH+TAG_WIDTH+2 ≤ 31
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- rpc_i  in  30 [31:2]  lookup PC
- update_i  in  1  write request
- upd_hit_i  in  1  entry already present in upd_way_i (from prediction metadata)
- upd_way_i  in  log2(WAYS) (min 1)  way to overwrite when upd_hit_i=1
- wpc_i  in  30 [31:2]  branch PC being updated
- bta_i  in  30 [31:2]  branch target
- br_type_i  in  2  branch type
- flush_i  in  1  invalidate all entries
- ready_o  out  1  0 while flushing
- miss_o  out  1  no valid tag match
- fsc_o  out  1  stored pc[2] of hit entry
- hit_way_o  out  log2(WAYS)  matching way (0 on miss)
- bta_o  out  30 [31:2]  predicted target
- br_type_o  out  2  predicted type

## Operation
- Storage: one sdpram per way, entry {valid, fsc, tag, bta, br_type}; valid lives in RAM, so invalidation means writing.
- Lookup: all ways are read at index(rpc_i), rpc_i is registered as pre_pc, and tags are compared against tag(pre_pc). If several ways match, the lowest way wins.
- Miss: bta_o = {pre_pc[31:3]+1, 1'b0} (fall-through to next 8-byte pair), br_type_o = `_PC_RELATIVE, fsc_o = 0, hit_way_o = 0.
- Update (state IDLE, update_i=1): write {1, wpc_i[2], tag(wpc_i), bta_i, br_type_i}.
  - If upd_hit_i: write way upd_way_i; the replacement pointer is untouched.
  - Else: write way rr[index(wpc_i)], then rr ← rr+1 (mod WAYS).
- Replacement state: rr array of 2^ADDR_WIDTH × log2(WAYS) flops, async reset to 0.
- FSM states:
  - FLUSH (entered on reset): counter cnt sweeps 0..2^ADDR_WIDTH−1, writing valid=0 to set cnt in all ways, one set per cycle. At cnt = max it goes to IDLE next cycle.
  - IDLE: flush_i=1 → FLUSH with cnt=0.
- During FLUSH: ready_o=0, update_i is ignored (dropped, not queued), and outputs are forced to miss.
- flush_i while in FLUSH restarts cnt at 0.
- Simultaneous update_i and flush_i in IDLE: flush wins and the update is dropped.
- Read and write to the same set in one cycle: the read returns old data (no bypass).

## Timing
- Lookup latency is 1 cycle: rpc_i at edge N gives outputs valid after edge N+1, combinational from RAM output and pre_pc.
- Update is visible to a lookup issued at least one cycle after the write cycle.
- Flush takes 2^ADDR_WIDTH cycles; ready_o rises the cycle after the last set is written.
- Reset values:
  - FSM = FLUSH, cnt = 0, pre_pc = 0, rr = 0.
  - ready_o = 0, miss_o = 1, fsc_o = 0, hit_way_o = 0.
  - bta_o = 30'h2 (byte address 0x8), br_type_o = `_PC_RELATIVE.
- Reset asserted mid-flush or mid-update aborts immediately; the sweep restarts from set 0 after release.

## Structure
- bpu.svh holds the branch-type constants (`_PC_RELATIVE etc.) and a packed btb_entry_t typedef parameterised via macros for TAG_WIDTH.
- Reuse the existing sdpram, one instance per way via generate. Write enable per way = (flush sweep) | (update & way select).
- The FSM, rr array and tag/index functions stay local to btb_assoc. No further sub-module.

## Test plan
- Post-reset: hold update_i=0 for 2^ADDR_WIDTH+1 cycles → ready_o=0 throughout the sweep then 1; lookup of 0x1000 → miss_o=1, bta_o=0x1008>>2.
- Allocate: update wpc=0x1004, bta=0x2000, upd_hit_i=0 → lookup 0x1004 next cycle gives miss_o=0, fsc_o=1, hit_way_o=0, bta_o=0x2000>>2.
- Conflict, WAYS=2: allocate three PCs mapping to one set (stride 2^(ADDR_WIDTH+3)) → third evicts first; first misses, second and third hit in ways 1 and 0.
- Hinted overwrite: upd_hit_i=1, upd_way_i=1, new bta=0x3000 → way 1 returns 0x3000 and the rr pointer is unchanged (next allocate uses the predicted way).
- Flush: flush_i with update_i in same cycle → update dropped, all prior entries miss after the sweep, ready_o low exactly 2^ADDR_WIDTH cycles.
- Reset asserted at cnt=5 → outputs return to reset values asynchronously and the sweep restarts at 0.
